// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg: shared FSM type, sizing constants and round-robin helper for MMIO arbitration.
package mmio_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam int MAX_REQ = 8;
  localparam int IDX_W = 3;
  // One-hot pick of the first valid bit after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_next(input logic [IDX_W-1:0] ptr,
                                                 input logic [MAX_REQ-1:0] valid,
                                                 input int n);
    logic [MAX_REQ-1:0] grant;
    logic [IDX_W-1:0] k;
    logic found;
    grant = '0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      k = IDX_W'((int'(ptr) + i) % n);
      if (i <= n && !found && valid[k]) begin
        grant[k] = 1'b1;
        found = 1'b1;
      end
    end
    return grant;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant over a masked request vector.
module rr_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  input  logic [NUM_REQ-1:0] mask,
  output logic [NUM_REQ-1:0] grant
);
  logic [MAX_REQ-1:0] pad_valid;
  logic [MAX_REQ-1:0] pad_grant;
  logic               unused_pad;
  always_comb begin
    pad_valid = '0;
    pad_valid[NUM_REQ-1:0] = valid & mask;
  end
  assign pad_grant  = rr_next(ptr, pad_valid, NUM_REQ);
  assign grant      = pad_grant[NUM_REQ-1:0];
  assign unused_pad = ^pad_grant;
endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: round-robin sharing of one MMIO peripheral bus, one 3-cycle transaction at a time.
// Define MMIO_ARB_LOCK_EN to let a requester hold the bus across transactions via req_lock.
module mmio_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic [ADDR_W-1:0]         address,
  output logic [DATA_W-1:0]         write_data,
  output logic                      write_enable,
  output logic                      read_enable,
  input  logic [DATA_W-1:0]         read_data
);
  state_t              state, next_state;
  logic [IDX_W-1:0]    rr_ptr, idx_q, gidx;
  logic                we_q, sel_we, take;
  logic [ADDR_W-1:0]   addr_q, sel_addr;
  logic [DATA_W-1:0]   wdata_q, sel_wdata;
  logic [NUM_REQ-1:0]  grant, mask;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .valid(req_valid),
    .ptr  (rr_ptr),
    .mask (mask),
    .grant(grant)
  );

  assign take = (state == IDLE) && |grant;

`ifdef MMIO_ARB_LOCK_EN
  logic             lock_held;
  logic [IDX_W-1:0] lock_owner;
  // Owner re-arms or releases the lock on each of its own handshakes.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lock_held  <= 1'b0;
      lock_owner <= '0;
    end else if (take) begin
      lock_held  <= |(req_lock & grant);
      lock_owner <= gidx;
    end
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) mask[i] = !lock_held || lock_owner == IDX_W'(i);
  end
`else
  logic unused_lock;
  assign mask        = '1;
  assign unused_lock = ^req_lock;
`endif

  always_comb begin
    gidx      = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) begin
        gidx      = IDX_W'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr  <= IDX_W'(NUM_REQ - 1);
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (take) begin
      rr_ptr  <= gidx;
      idx_q   <= gidx;
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= next_state;

  always_comb
    next_state = (state == IDLE)  ? (take ? ISSUE : IDLE) :
                 (state == ISSUE) ? RESP : IDLE;

  // Outputs decode straight from state so a reset drops strobes without waiting for a clock.
  always_comb begin
    req_ready    = (state == IDLE) ? grant : '0;
    write_enable = (state == ISSUE) && we_q;
    read_enable  = (state == ISSUE) && !we_q;
    address      = (state == ISSUE) ? addr_q : '0;
    write_data   = (state == ISSUE) ? wdata_q : '0;
    resp_rdata   = (state == RESP && !we_q) ? read_data : '0;
    resp_valid   = '0;
    for (int i = 0; i < NUM_REQ; i++) resp_valid[i] = (state == RESP) && idx_q == IDX_W'(i);
  end
endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: table-driven check of mmio_arbiter against a small registered-read peripheral model.
module tb_mmio_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0, req_ready, req_we = '0, req_lock = '0, resp_valid;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [31:0] resp_rdata, address, write_data, read_data = '0;
  logic        write_enable, read_enable;
  logic [31:0] mem [16] = '{default: 32'h0};
  int          checks = 0, failures = 0;

  typedef struct {
    logic [1:0]  valid, we;
    logic [31:0] a0, a1, d0, d1;
    logic [1:0]  grant;
    logic [31:0] rdata;
  } vec_t;
  vec_t tbl [8];

  mmio_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_lock(req_lock), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .address(address), .write_data(write_data),
    .write_enable(write_enable), .read_enable(read_enable), .read_data(read_data)
  );

  always #5 clk = ~clk;

  // GPIO-like peripheral: word registers, read data registered one cycle after read_enable.
  always @(posedge clk) begin
    if (write_enable) mem[address[5:2]] <= write_data;
    if (read_enable) read_data <= mem[address[5:2]];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic        ew;
    logic [31:0] ea, ed;
    req_valid = v.valid;
    req_we    = v.we;
    req_addr  = {v.a1, v.a0};
    req_wdata = {v.d1, v.d0};
    ew = v.grant[0] ? v.we[0] : v.we[1];
    ea = v.grant[0] ? v.a0 : v.a1;
    ed = v.grant[0] ? v.d0 : v.d1;
    #1;
    chk("idle_ready", 32'(req_ready), 32'(v.grant));
    step();
    chk("issue_we", 32'(write_enable), 32'(ew));
    chk("issue_re", 32'(read_enable), 32'(!ew));
    chk("issue_addr", address, ea);
    chk("issue_wdata", write_data, ed);
    chk("issue_ready", 32'(req_ready), 32'h0);
    chk("issue_resp", 32'(resp_valid), 32'h0);
    step();
    chk("resp_valid", 32'(resp_valid), 32'(v.grant));
    chk("resp_rdata", resp_rdata, v.rdata);
    chk("resp_strobes", 32'({write_enable, read_enable}), 32'h0);
    chk("resp_addr", address, 32'h0);
    chk("resp_ready", 32'(req_ready), 32'h0);
    step();
  endtask

  initial begin
    tbl[0] = '{2'b01, 2'b01, 32'hA000_0000, 32'h0,         32'hFF, 32'h0,  2'b01, 32'h0};
    tbl[1] = '{2'b10, 2'b00, 32'h0,         32'hA000_0000, 32'h0,  32'h0,  2'b10, 32'hFF};
    tbl[2] = '{2'b11, 2'b01, 32'hA000_0004, 32'hA000_0000, 32'h11, 32'h0,  2'b01, 32'h0};
    tbl[3] = '{2'b11, 2'b01, 32'hA000_0004, 32'hA000_0000, 32'h11, 32'h0,  2'b10, 32'hFF};
    tbl[4] = '{2'b11, 2'b10, 32'hA000_0004, 32'hA000_0008, 32'h0,  32'h22, 2'b01, 32'h11};
    tbl[5] = '{2'b11, 2'b10, 32'hA000_0004, 32'hA000_0008, 32'h0,  32'h22, 2'b10, 32'h0};
    tbl[6] = '{2'b11, 2'b00, 32'hA000_0008, 32'hA000_0004, 32'h0,  32'h0,  2'b01, 32'h22};
    tbl[7] = '{2'b11, 2'b00, 32'hA000_0008, 32'hA000_0004, 32'h0,  32'h0,  2'b10, 32'h11};
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_resp", 32'(resp_valid), 32'h0);
    chk("rst_strobes", 32'({write_enable, read_enable}), 32'h0);
    chk("rst_addr", address, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i]);
      if (i == 0) chk("gpio_out", mem[0], 32'hFF);
    end
    // Reset during ISSUE of a write: strobe drops at once and rr_ptr returns to favour requester 0.
    req_valid = 2'b01;
    req_we    = 2'b01;
    req_addr  = {32'h0, 32'hA000_000C};
    req_wdata = {32'h0, 32'h33};
    #1;
    chk("mid_ready", 32'(req_ready), 32'h1);
    step();
    chk("mid_we", 32'(write_enable), 32'h1);
    #2;
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    chk("mid_we_drop", 32'(write_enable), 32'h0);
    chk("mid_addr_drop", address, 32'h0);
    chk("mid_resp", 32'(resp_valid), 32'h0);
    step();
    chk("mid_resp2", 32'(resp_valid), 32'h0);
    step();
    rst_n = 1'b1;
    chk("mid_no_write", mem[3], 32'h0);
    run_vec('{2'b11, 2'b00, 32'hA000_0000, 32'hA000_0004, 32'h0, 32'h0, 2'b01, 32'hFF});
    // Back-to-back reads from requester 1: one handshake every 3 cycles, data tracks each read.
    run_vec('{2'b10, 2'b00, 32'h0, 32'hA000_0000, 32'h0, 32'h0, 2'b10, 32'hFF});
    run_vec('{2'b10, 2'b00, 32'h0, 32'hA000_0004, 32'h0, 32'h0, 2'b10, 32'h11});
    run_vec('{2'b10, 2'b00, 32'h0, 32'hA000_0008, 32'h0, 32'h0, 2'b10, 32'h22});
`ifdef MMIO_ARB_LOCK_EN
    req_lock = 2'b10;
    run_vec('{2'b10, 2'b00, 32'hA000_0000, 32'hA000_0004, 32'h0, 32'h0, 2'b10, 32'h11});
    req_lock = 2'b00;
    run_vec('{2'b11, 2'b10, 32'hA000_0000, 32'hA000_0008, 32'h0, 32'h33, 2'b10, 32'h0});
    run_vec('{2'b11, 2'b00, 32'hA000_0000, 32'hA000_0008, 32'h0, 32'h0, 2'b01, 32'hFF});
`endif
    req_valid = 2'b00;
    #1;
    chk("final_idle", 32'(req_ready), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
